// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: client-side initiator for the datamem data-memory port.
// Turns single/burst read or write requests into one memory cycle per beat
// on sequential (wrapping) word addresses, and returns read beats over a
// valid/ready response channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_we, req_addr, req_len (beats-1)
//   wr_valid/wr_ready        write-beat handshake; wr_data
//   rsp_valid/rsp_ready      read-beat handshake; rsp_data
//   done                     one-cycle pulse when a request has fully completed
//   we_DM, addDM, dataDM     registered memory write enable, address, write data
//   outDM                    memory read data, valid RD_LAT cycles after addDM
module dm_access_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              done,
    output logic              we_DM,
    output logic [ADDR_W-1:0] addDM,
    output logic [DATA_W-1:0] dataDM,
    input  logic [DATA_W-1:0] outDM
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        LAT_INIT = 2'(RD_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdAddr,
        StRdWait,
        StRdRsp
    } state_e;

    state_e            r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat_cnt;
    logic [1:0]        r_lat_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_done;

    logic w_last;
    logic w_req_ready;

    assign w_last = (r_beat_cnt == r_len);

    // The cycle carrying done is still idle but refuses a new request, so a
    // completion pulse never coincides with acceptance of the next request.
    assign w_req_ready = !rst && (r_state == StIdle) && !r_done;

    assign req_ready = w_req_ready;
    assign wr_ready  = !rst && (r_state == StWr);
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign done      = r_done;
    assign we_DM     = r_we;
    assign addDM     = r_addr;
    assign dataDM    = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cur_addr  <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_lat_cnt   <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_we <= 1'b0;
                    if (req_valid && w_req_ready) begin
                        r_cur_addr <= req_addr;
                        r_len      <= req_len;
                        r_beat_cnt <= '0;
                        r_state    <= req_we ? StWr : StRdAddr;
                    end
                end
                StWr: begin
                    if (wr_valid) begin
                        r_we       <= 1'b1;
                        r_addr     <= r_cur_addr;
                        r_data     <= wr_data;
                        r_cur_addr <= r_cur_addr + ADDR_ONE;
                        r_beat_cnt <= r_beat_cnt + LEN_ONE;
                        if (w_last) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        // Stalled beat: no memory write, address not advanced.
                        r_we <= 1'b0;
                    end
                end
                StRdAddr: begin
                    r_we      <= 1'b0;
                    r_addr    <= r_cur_addr;
                    r_lat_cnt <= LAT_INIT;
                    r_state   <= StRdWait;
                end
                StRdWait: begin
                    if (r_lat_cnt == 2'd0) begin
                        r_rsp_data  <= outDM;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StRdRsp;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 2'd1;
                    end
                end
                StRdRsp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end else begin
                            r_cur_addr <= r_cur_addr + ADDR_ONE;
                            r_beat_cnt <= r_beat_cnt + LEN_ONE;
                            r_state    <= StRdAddr;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios plus randomized
// bursts, checked each cycle against a queue/array model of the memory side.
module tb_dm_access_ctrl;

    localparam int LAT = 1;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
        bit          last;
    } wr_t;

    typedef struct {
        logic [31:0] d;
        bit          last;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [11:0] req_addr;
    logic [3:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        done, we_DM;
    logic [11:0] addDM;
    logic [31:0] dataDM, outDM;

    // Second instance with a longer read latency.
    logic        l_req_valid, l_req_ready, l_wr_ready, l_rsp_valid, l_done, l_we_DM;
    logic [31:0] l_rsp_data, l_dataDM, l_outDM, l_p1, l_p2;
    logic [11:0] l_addDM;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    bit rd_last_pend = 1'b0;

    wr_t         exp_wr[$];
    rd_t         exp_rd[$];
    logic [11:0] wr_log[$];
    logic [31:0] exp_mem[4096];
    logic [31:0] mem[4096];
    bit          written[4096];
    logic [31:0] out_q;

    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_W(12), .DATA_W(32), .LEN_W(4), .RD_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .done(done), .we_DM(we_DM), .addDM(addDM), .dataDM(dataDM), .outDM(outDM)
    );

    dm_access_ctrl #(.ADDR_W(12), .DATA_W(32), .LEN_W(4), .RD_LAT(2)) u_lat (
        .clk(clk), .rst(rst),
        .req_valid(l_req_valid), .req_ready(l_req_ready), .req_we(1'b0),
        .req_addr(12'h123), .req_len(4'd0),
        .wr_valid(1'b0), .wr_ready(l_wr_ready), .wr_data(32'd0),
        .rsp_valid(l_rsp_valid), .rsp_ready(1'b1), .rsp_data(l_rsp_data),
        .done(l_done), .we_DM(l_we_DM), .addDM(l_addDM), .dataDM(l_dataDM), .outDM(l_outDM)
    );

    function automatic logic [31:0] init_val(input logic [11:0] a);
        return 32'h5A5A0000 ^ ({20'd0, a} * 32'h9E3779B1);
    endfunction

    function automatic logic [31:0] memval(input logic [11:0] a);
        return written[a] ? mem[a] : init_val(a);
    endfunction

    // Memory for the main instance: one-cycle registered read.
    always @(posedge clk) begin
        if (we_DM) begin
            mem[addDM]     <= dataDM;
            written[addDM] <= 1'b1;
        end
        out_q <= memval(addDM);
    end
    assign outDM = out_q;

    // Memory for the latency instance: two-stage read, contents derived from address.
    always @(posedge clk) begin
        l_p1 <= 32'hAB000000 | {20'd0, l_addDM};
        l_p2 <= l_p1;
    end
    assign l_outDM = l_p2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model queues.
    always @(negedge clk) begin : mon
        wr_t w;
        rd_t r;
        bit  exp_done;
        if (mon_en) begin
            exp_done     = rd_last_pend;
            rd_last_pend = 1'b0;
            if (done) done_cnt++;
            if (rst) chk("req_ready_in_rst", 64'(req_ready), 64'd0);
            if (we_DM) begin
                wr_log.push_back(addDM);
                chk("spurious_we", 64'(exp_wr.size() == 0), 64'd0);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    chk("we_addr", 64'(addDM), 64'(w.a));
                    chk("we_data", 64'(dataDM), 64'(w.d));
                    if (w.last) exp_done = 1'b1;
                end
            end
            chk("done", 64'(done), 64'(exp_done));
            if (rsp_valid && rsp_ready) begin
                chk("spurious_rsp", 64'(exp_rd.size() == 0), 64'd0);
                if (exp_rd.size() != 0) begin
                    r = exp_rd.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(r.d));
                    if (r.last) rd_last_pend = 1'b1;
                end
            end
            chk("ready_overlap", 64'(req_ready && (done || rsp_valid)), 64'd0);
        end
    end

    // Hold checks while a response is stalled.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [11:0] prev_addr;
    always @(negedge clk) begin
        if (mon_en && prev_hold) begin
            chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_hold_data", 64'(rsp_data), 64'(prev_data));
            chk("rsp_hold_addr", 64'(addDM), 64'(prev_addr));
        end
        prev_hold <= rsp_valid && !rsp_ready && !rst;
        prev_data <= rsp_data;
        prev_addr <= addDM;
    end

    task automatic req_hs(input bit we, input logic [11:0] addr, input int len);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_len   = 4'(len);
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("req_timeout", 64'(n >= 50), 64'd0);
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] addr, input int len, input logic [31:0] d0,
                            input int gapfix, input int gapmax, input int rst_after);
        int          n;
        int          g;
        logic [11:0] a;
        logic [31:0] d;
        wr_t         e;
        req_hs(1'b1, addr, len);
        a = addr;
        for (int i = 0; i <= len; i++) begin
            if (i > 0) begin
                g = (gapfix >= 0) ? gapfix : int'($urandom_range(gapmax, 0));
                wr_valid = 1'b0;
                repeat (g) step();
            end
            d = (i == 0) ? d0 : $urandom;
            wr_valid = 1'b1;
            wr_data  = d;
            n = 0;
            while (!wr_ready && n < 50) begin
                step();
                n++;
            end
            chk("wr_timeout", 64'(n >= 50), 64'd0);
            e.a = a;
            e.d = d;
            e.last = (i == len);
            exp_wr.push_back(e);
            exp_mem[a] = d;
            a = a + 12'd1;
            step();
            if (i == rst_after) begin
                wr_valid = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                return;
            end
        end
        wr_valid = 1'b0;
        step();
        step();
    endtask

    task automatic do_read(input logic [11:0] addr, input int len, input bit fast,
                           input int stall0, input int stallmax, output logic [31:0] last_d);
        int  n;
        int  s;
        rd_t r;
        last_d = '0;
        for (int i = 0; i <= len; i++) begin
            r.d = exp_mem[12'(addr + 12'(i))];
            r.last = (i == len);
            exp_rd.push_back(r);
        end
        rsp_ready = fast;
        req_hs(1'b0, addr, len);
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!rsp_valid && n < 50) begin
                step();
                n++;
            end
            chk("rsp_timeout", 64'(n >= 50), 64'd0);
            // With rsp_ready held high every beat takes 3+RD_LAT cycles.
            if (fast) chk("rd_beat_period", 64'(n + 1), 64'(3 + LAT));
            last_d = rsp_data;
            if (!fast) begin
                s = (i == 0 && stall0 >= 0) ? stall0 : int'($urandom_range(stallmax, 0));
                repeat (s) step();
                rsp_ready = 1'b1;
            end
            step();
            if (!fast) rsp_ready = 1'b0;
        end
        rsp_ready = 1'b0;
        step();
        step();
    endtask

    logic [31:0] rd_last;
    int          d_before;
    int          n;
    int          bad;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0; l_req_valid = 1'b0;
        for (int i = 0; i < 4096; i++) exp_mem[i] = init_val(12'(i));
        repeat (3) step();

        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_we_DM", 64'(we_DM), 64'd0);
        chk("rst_addDM", 64'(addDM), 64'd0);
        chk("rst_dataDM", 64'(dataDM), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        step();
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // 1: single write then single read of the same word
        wr_log.delete();
        d_before = done_cnt;
        do_write(12'h001, 0, 32'h1dfe, 0, 0, -1);
        do_read(12'h001, 0, 1'b1, -1, 0, rd_last);
        chk("t1_rsp_data", 64'(rd_last), 64'h1dfe);
        chk("t1_we_count", 64'(wr_log.size()), 64'd1);
        chk("t1_we_addr", 64'(wr_log[0]), 64'h001);
        chk("t1_done_count", 64'(done_cnt - d_before), 64'd2);

        // 2: wrapping burst of 4 and read-back
        wr_log.delete();
        do_write(12'hFFE, 3, 32'hA0A0A0A0, 0, 0, -1);
        chk("t2_we_count", 64'(wr_log.size()), 64'd4);
        chk("t2_we_addr0", 64'(wr_log[0]), 64'hFFE);
        chk("t2_we_addr1", 64'(wr_log[1]), 64'hFFF);
        chk("t2_we_addr2", 64'(wr_log[2]), 64'h000);
        chk("t2_we_addr3", 64'(wr_log[3]), 64'h001);
        do_read(12'hFFE, 3, 1'b1, -1, 0, rd_last);

        // 3: write with two-cycle gaps between beats
        wr_log.delete();
        do_write(12'h200, 2, $urandom, 2, 0, -1);
        chk("t3_we_count", 64'(wr_log.size()), 64'd3);
        chk("t3_we_addr0", 64'(wr_log[0]), 64'h200);
        chk("t3_we_addr2", 64'(wr_log[2]), 64'h202);

        // 4: read with five-cycle response stall on beat 0
        do_read(12'h200, 1, 1'b0, 5, 0, rd_last);

        // 5: reset after beat 1 of an 8-beat write
        wr_log.delete();
        do_write(12'h300, 7, $urandom, 0, 0, 1);
        @(negedge clk);
        chk("t5_we_after_rst", 64'(we_DM), 64'd0);
        chk("t5_req_ready", 64'(req_ready), 64'd1);
        chk("t5_addDM", 64'(addDM), 64'd0);
        chk("t5_dataDM", 64'(dataDM), 64'd0);
        step();
        chk("t5_we_count", 64'(wr_log.size()), 64'd2);
        bad = 0;
        for (int k = 0; k < 8; k++)
            if (memval(12'(12'h300 + 12'(k))) !== exp_mem[12'(12'h300 + 12'(k))]) bad++;
        chk("t5_mem_region", 64'(bad), 64'd0);
        do_read(12'h300, 7, 1'b1, -1, 0, rd_last);

        // Maximal bursts across the wrap point
        do_write(12'hFF8, 15, $urandom, -1, 2, -1);
        do_read(12'hFF8, 15, 1'b1, -1, 0, rd_last);
        do_read(12'hFF8, 15, 1'b0, -1, 3, rd_last);

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            logic [11:0] ra;
            int          rl;
            ra = ($urandom_range(3, 0) == 0) ? 12'(12'hFF0 + 12'($urandom_range(15, 0)))
                                             : 12'($urandom);
            rl = int'($urandom_range(15, 0));
            if ($urandom_range(1, 0) == 1)
                do_write(ra, rl, $urandom, -1, int'($urandom_range(3, 0)), -1);
            else
                do_read(ra, rl, 1'($urandom_range(1, 0)), -1, int'($urandom_range(4, 0)),
                        rd_last);
        end

        // 6: RD_LAT=2 instance, single read
        l_req_valid = 1'b1;
        n = 0;
        while (!l_req_ready && n < 50) begin
            step();
            n++;
        end
        chk("t6_req_timeout", 64'(n >= 50), 64'd0);
        step();
        l_req_valid = 1'b0;
        n = 0;
        while (!l_rsp_valid && n < 50) begin
            step();
            n++;
        end
        chk("t6_latency", 64'(n + 1), 64'd5);
        chk("t6_rsp_data", 64'(l_rsp_data), 64'hAB000123);
        step();
        chk("t6_done", 64'(l_done), 64'd1);
        chk("t6_no_write", 64'(l_we_DM), 64'd0);

        step();
        step();
        chk("exp_wr_drained", 64'(exp_wr.size()), 64'd0);
        chk("exp_rd_drained", 64'(exp_rd.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++)
            if (memval(12'(i)) !== exp_mem[i]) bad++;
        chk("final_mem", 64'(bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
